hs_pulse_rx: RTL
================

HS_PULSE_RX -- requirements
Module: hs_pulse_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, legal 2..4: number of synchronizer flops on req_in.
REQ-002 SHALL have parameter CNT_W, default 16: width of the delivered-event counter.
REQ-003 SHALL have port clkb  input  1  destination (slow) clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port req_in  input  1  asynchronous request level from the source domain, the stretched/knotted pulse held until ack.
REQ-006 SHALL have port ack_out  output  1  registered acknowledge level, synchronized back by the source domain.
REQ-007 SHALL have port evt_valid  output  1  one captured event is pending for the downstream consumer.
REQ-008 SHALL have port evt_ready  input  1  downstream accepts the event when evt_valid and evt_ready are both high at a clkb edge.
REQ-009 SHALL have port evt_cnt  output  CNT_W  count of accepted events, wrapping.
REQ-010 SHALL have port proto_err  output  1  sticky flag: req_in withdrawn before the event was accepted.
REQ-011 SHALL have port err_clr  input  1  synchronous clear of proto_err.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL pass req_in through a SYNC_STAGES-deep flop chain; req_s is the last stage, and no logic other than the chain SHALL sample req_in.
REQ-014 SHALL implement a four-phase responder FSM with states IDLE, DELIVER and ACK.
REQ-015 IDLE: on req_s=1 SHALL go to DELIVER at the next edge; otherwise SHALL stay in IDLE.
REQ-016 DELIVER: evt_valid=1; on evt_valid&evt_ready SHALL go to ACK and increment evt_cnt by 1 at the same edge.
REQ-017 ACK: ack_out=1; on req_s=0 SHALL go to IDLE and drive ack_out=0 at the same edge.
REQ-018 evt_valid and ack_out SHALL be flop outputs with no combinational path from evt_ready or req_in.
REQ-019 Latency: if req_in first rises and is captured at edge k, evt_valid SHALL be high after edge k+SYNC_STAGES.
REQ-020 Latency: ack_out SHALL rise at the edge following the accepting edge, with exactly one event delivered per request.
REQ-021 When evt_ready is already high as evt_valid rises, acceptance SHALL occur in the first evt_valid cycle (evt_valid high for exactly 1 cycle).
REQ-022 evt_valid SHALL stay high with no timeout while evt_ready is low, and the FSM SHALL remain in DELIVER.
REQ-023 If req_s=0 while in DELIVER, proto_err SHALL be set; the event SHALL still be delivered; the FSM then passes through ACK for 1 cycle and returns to IDLE.
REQ-024 Simultaneous err_clr and an error set condition: set SHALL win.
REQ-025 evt_cnt SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-026 After ACK->IDLE, a new event SHALL require req_s to be seen high again, so a held-high req_in SHALL NOT re-trigger.
REQ-027 busy SHALL equal (state != IDLE), registered or decoded from the state register.

Reset
REQ-028 On rst_n=0 at a clkb edge, the block SHALL set: state=IDLE, all sync flops=0, ack_out=0, evt_valid=0, evt_cnt=0, proto_err=0, busy=0.
REQ-029 Reset mid-handshake (DELIVER or ACK) SHALL abandon the pending event without counting it.
REQ-030 After reset mid-handshake, ack_out SHALL be low, and a req_in still high after reset release SHALL be treated as a new request.

Verification
REQ-031 Basic: SYNC_STAGES=2, evt_ready=1, req_in 0->1 captured at edge 0 -> evt_valid high cycle after edge 2 for 1 cycle, ack_out=1 after edge 3, evt_cnt=1; drop req_in -> ack_out=0 two edges after capture of the fall, busy=0.
REQ-032 Backpressure: evt_ready=0 for 10 cycles after evt_valid rises -> evt_valid held 10 cycles, ack_out stays 0, evt_cnt unchanged; evt_ready=1 -> evt_cnt increments by 1 and ack_out rises next edge.
REQ-033 Protocol error: req_in dropped while in DELIVER with evt_ready=0 -> proto_err=1 and stays 1; evt_ready=1 -> one event counted, FSM returns to IDLE; err_clr=1 -> proto_err=0 next edge.
REQ-034 Wrap: CNT_W=4, 16 full handshakes -> evt_cnt returns to 0; req_in held high after ACK -> no 17th event.
REQ-035 Reset mid-op: rst_n=0 for 1 cycle during DELIVER -> all outputs 0, evt_cnt=0; req_in still high -> new event delivered SYNC_STAGES+1 cycles after release.

Source files
------------

// File: rtl/hs_pulse_rx.sv
// Destination-side responder of a four-phase req/ack pulse crossing: synchronizes the
// request level, presents one event per request to a valid/ready consumer, then acknowledges.
module hs_pulse_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clkb,
    input  logic             rst_n,
    input  logic             req_in,
    output logic             ack_out,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             proto_err,
    input  logic             err_clr,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        ACK     = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic                   accept;
    logic                   err_set;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Synchronizer chain: the only logic that samples the asynchronous req_in
    always_ff @(posedge clkb) begin
        if (!rst_n) begin
            req_sync <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req_in};
        end
    end

    assign req_s = req_sync[SYNC_STAGES-1];

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (req_s) begin
                    state_nxt = DELIVER;
                end
            end
            DELIVER: begin
                // A withdrawn request is flagged but the event is still handed over
                if (!req_s) begin
                    err_set = 1'b1;
                end
                if (evt_valid && evt_ready) begin
                    accept    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so nothing combinational reaches the ports
    always_ff @(posedge clkb) begin
        if (!rst_n) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            ack_out   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            evt_valid <= (state_nxt == DELIVER);
            ack_out   <= (state_nxt == ACK);
            busy      <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clkb) begin
        if (!rst_n) begin
            evt_cnt <= '0;
        end else if (accept) begin
            evt_cnt <= cnt_inc(evt_cnt);
        end
    end

    // Set has priority over a coincident clear
    always_ff @(posedge clkb) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (err_set) begin
            proto_err <= 1'b1;
        end else if (err_clr) begin
            proto_err <= 1'b0;
        end
    end

endmodule
